// File: rtl/pipelined_addsub.sv
`timescale 1ns / 1ps
// -----------------------------------------------------------------------------
// pipelined_addsub
//
// Pipelined integer adder/subtractor with NZCV flag generation and a
// valid/ready handshake. The WIDTH-bit carry chain is cut into STAGES equal
// segments of SEG = WIDTH/STAGES bits. Register stage k holds the sum bits
// resolved so far (segments 0..k), the still-unprocessed upper operand bits,
// the carry out of segment k, the operand MSBs and a valid bit.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears every valid bit and datum
//   in_valid   operands presented
//   in_ready   block accepts operands this cycle (combinational, = advance)
//   in_a/in_b  WIDTH-bit operands
//   in_sub     0: A+B, 1: A-B (computed as A + ~B + 1)
//   out_valid  result available
//   out_ready  consumer accepts the result
//   out_sum    WIDTH-bit result, modulo 2^WIDTH
//   out_flags  {N, Z, C, V}; C=1 on subtract means "no borrow"
// -----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic [3:0]       out_flags
);

  localparam int unsigned SEG  = WIDTH / STAGES;
  localparam int unsigned LAST = STAGES - 1;

  // Elaboration-time parameter checks.
  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipelined_addsub: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end
  if ((WIDTH < 8) || (WIDTH > 128)) begin : g_bad_width
    $error("pipelined_addsub: WIDTH (%0d) must lie in 8..128", WIDTH);
  end
  if ((STAGES < 1) || (STAGES > 8)) begin : g_bad_stages
    $error("pipelined_addsub: STAGES (%0d) must lie in 1..8", STAGES);
  end

  // Per-stage state. a/b keep the full width for simplicity; stage k only
  // ever reads the slices above segment k.
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [STAGES-1:0] carry_q, carry_d;
  logic [STAGES-1:0] a_msb_q, a_msb_d;
  logic [STAGES-1:0] b_msb_q, b_msb_d;
  logic [STAGES-1:0] valid_q, valid_d;

  logic             adv;
  logic [WIDTH-1:0] beff;
  logic [SEG:0]     seg_res;

  // Single global advance: the whole pipe moves or the whole pipe holds, so a
  // bubble stays where it is during a stall.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;
  assign beff     = in_sub ? ~in_b : in_b;

  always_comb begin
    seg_res = '0;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    valid_d = valid_q;

    if (adv) begin
      // Stage 0: lowest segment straight from the inputs; in_sub is the +1 of
      // two's-complement subtraction. Data loads even on a bubble; the valid
      // bit alone qualifies it.
      seg_res          = {1'b0, in_a[SEG-1:0]} + {1'b0, beff[SEG-1:0]} + {{SEG{1'b0}}, in_sub};
      sum_d[0]         = '0;
      sum_d[0][SEG-1:0] = seg_res[SEG-1:0];
      a_d[0]           = in_a;
      b_d[0]           = beff;
      carry_d[0]       = seg_res[SEG];
      a_msb_d[0]       = in_a[WIDTH-1];
      b_msb_d[0]       = beff[WIDTH-1];
      valid_d[0]       = in_valid & in_ready;

      // Stage k: resolve segment k using the carry registered by stage k-1.
      for (int unsigned k = 1; k < STAGES; k++) begin
        seg_res = {1'b0, a_q[k-1][k*SEG +: SEG]} + {1'b0, b_q[k-1][k*SEG +: SEG]}
                + {{SEG{1'b0}}, carry_q[k-1]};
        sum_d[k]              = sum_q[k-1];
        sum_d[k][k*SEG +: SEG] = seg_res[SEG-1:0];
        a_d[k]                = a_q[k-1];
        b_d[k]                = b_q[k-1];
        carry_d[k]            = seg_res[SEG];
        a_msb_d[k]            = a_msb_q[k-1];
        b_msb_d[k]            = b_msb_q[k-1];
        valid_d[k]            = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
      carry_q <= '0;
      a_msb_q <= '0;
      b_msb_q <= '0;
      valid_q <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_d[k];
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
      end
      carry_q <= carry_d;
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      valid_q <= valid_d;
    end
  end

  logic flag_n, flag_z, flag_c, flag_v;

  always_comb begin
    out_valid = valid_q[LAST];
    out_sum   = sum_q[LAST];
    flag_n    = sum_q[LAST][WIDTH-1];
    flag_z    = (sum_q[LAST] == '0);
    flag_c    = carry_q[LAST];
    // Signed overflow: operands of equal sign yielding a result of the other sign.
    flag_v    = (a_msb_q[LAST] == b_msb_q[LAST]) & (sum_q[LAST][WIDTH-1] != a_msb_q[LAST]);
    // Qualified by valid so the reset/idle value reads 0000 rather than Z=1.
    out_flags = out_valid ? {flag_n, flag_z, flag_c, flag_v} : 4'b0000;
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns / 1ps
module tb_pipelined_addsub;

  localparam int unsigned W = 64;
  localparam int unsigned S = 2;

  typedef logic [131:0] res_t;  // {flags[3:0], sum zero-extended to 128 bits}

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main DUT (64, 2) for directed tests.
  logic          in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [W-1:0]  in_a, in_b, out_sum;
  logic [3:0]    out_flags;

  pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_flags(out_flags)
  );

  // Sweep instances sharing one random stimulus stream.
  logic         sw_in_valid, sw_sub, sw_out_ready;
  logic [127:0] sw_a, sw_b;
  logic         ir0, ir1, ir2, ir3, ov0, ov1, ov2, ov3;
  logic [7:0]   s8;
  logic [31:0]  s32;
  logic [63:0]  s64;
  logic [127:0] s128;
  logic [3:0]   fl0, fl1, fl2, fl3;

  pipelined_addsub #(.WIDTH(8), .STAGES(1)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir0), .in_a(sw_a[7:0]),
    .in_b(sw_b[7:0]), .in_sub(sw_sub), .out_valid(ov0), .out_ready(sw_out_ready),
    .out_sum(s8), .out_flags(fl0)
  );
  pipelined_addsub #(.WIDTH(32), .STAGES(4)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir1), .in_a(sw_a[31:0]),
    .in_b(sw_b[31:0]), .in_sub(sw_sub), .out_valid(ov1), .out_ready(sw_out_ready),
    .out_sum(s32), .out_flags(fl1)
  );
  pipelined_addsub #(.WIDTH(64), .STAGES(8)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir2), .in_a(sw_a[63:0]),
    .in_b(sw_b[63:0]), .in_sub(sw_sub), .out_valid(ov2), .out_ready(sw_out_ready),
    .out_sum(s64), .out_flags(fl2)
  );
  pipelined_addsub #(.WIDTH(128), .STAGES(2)) u_sw3 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir3), .in_a(sw_a),
    .in_b(sw_b), .in_sub(sw_sub), .out_valid(ov3), .out_ready(sw_out_ready),
    .out_sum(s128), .out_flags(fl3)
  );

  logic sw_ir [4];
  logic sw_ov [4];
  res_t sw_res [4];
  always_comb begin
    sw_ir[0] = ir0; sw_ir[1] = ir1; sw_ir[2] = ir2; sw_ir[3] = ir3;
    sw_ov[0] = ov0; sw_ov[1] = ov1; sw_ov[2] = ov2; sw_ov[3] = ov3;
    sw_res[0] = {fl0, 128'(s8)};
    sw_res[1] = {fl1, 128'(s32)};
    sw_res[2] = {fl2, 128'(s64)};
    sw_res[3] = {fl3, s128};
  end

  int   n_checks = 0;
  int   n_fail = 0;
  int   main_outs = 0;
  int   sw_acc [4] = '{0, 0, 0, 0};
  res_t main_q [$];
  res_t sw_q [4][$];

  task automatic check(input string name, input res_t act, input res_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic, no segmentation.
  function automatic res_t model(input logic [127:0] a, input logic [127:0] b,
                                 input logic sub, input int w);
    logic [128:0] mask, am, bm, full;
    logic n, z, c, v;
    mask = (129'(1) << w) - 129'(1);
    am   = {1'b0, a} & mask;
    bm   = {1'b0, (sub ? ~b : b)} & mask;
    full = am + bm + 129'(sub);
    c    = full[w];
    full = full & mask;
    n    = full[w-1];
    z    = (full == '0);
    v    = (am[w-1] == bm[w-1]) && (n != am[w-1]);
    return {n, z, c, v, full[127:0]};
  endfunction

  function automatic int sw_width(input int i);
    case (i)
      0:       return 8;
      1:       return 32;
      2:       return 64;
      default: return 128;
    endcase
  endfunction

  function automatic int sw_stages(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      2:       return 8;
      default: return 2;
    endcase
  endfunction

  // Scoreboards: push on accepted input, pop on delivered output.
  always @(negedge clk) begin : mon_main
    res_t e;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        main_outs++;
        if (main_q.size() == 0) check("main_unexpected_out", 132'(out_valid), 132'(0));
        else begin
          e = main_q.pop_front();
          check("main_scoreboard", {out_flags, 128'(out_sum)}, e);
        end
      end
      if (in_valid && in_ready) main_q.push_back(model(128'(in_a), 128'(in_b), in_sub, 64));
    end
  end

  always @(negedge clk) begin : mon_sweep
    res_t e;
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (sw_ov[i] && sw_out_ready) begin
          if (sw_q[i].size() == 0)
            check($sformatf("sweep%0d_unexpected_out", i), 132'(sw_ov[i]), 132'(0));
          else begin
            e = sw_q[i].pop_front();
            check($sformatf("sweep%0d_scoreboard", i), sw_res[i], e);
          end
        end
        if (sw_in_valid && sw_ir[i]) begin
          sw_q[i].push_back(model(sw_a, sw_b, sw_sub, sw_width(i)));
          sw_acc[i]++;
        end
      end
    end
  end

  // One op on the main DUT with out_ready=1; checks latency, sum and flags.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        input logic [63:0] es, input logic [3:0] ef, input string name);
    int cnt;
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = {$urandom, $urandom}; in_b = {$urandom, $urandom};
    cnt = 1;
    while (!out_valid && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({name, "_latency"}, 132'(cnt), 132'(S));
    check({name, "_sum"}, 132'(out_sum), 132'(es));
    check({name, "_flags"}, 132'(out_flags), 132'(ef));
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic [63:0] sum;
    logic [3:0]  flags;
  } vec_t;

  vec_t vecs [7];
  int   idx, outs0, cyc, min_acc;
  logic acc;
  int   lat [4];

  initial begin
    vecs[0] = '{64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    vecs[1] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000};
    vecs[2] = '{64'h1234, 64'h1234, 1'b1, 64'h0, 4'b0110};
    vecs[3] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110};
    vecs[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
    vecs[6] = '{64'h0000_0001_0000_0000, 64'h1, 1'b1, 64'h0000_0000_FFFF_FFFF, 4'b0010};

    in_valid = 0; in_a = '0; in_b = '0; in_sub = 0; out_ready = 1;
    sw_in_valid = 0; sw_a = '0; sw_b = '0; sw_sub = 0; sw_out_ready = 1;

    // Reset state.
    #12;
    check("reset_out_valid", 132'(out_valid), 132'(0));
    check("reset_out_sum", 132'(out_sum), 132'(0));
    check("reset_out_flags", 132'(out_flags), 132'(0));
    check("reset_in_ready", 132'(in_ready), 132'(1));
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].sum, vecs[i].flags,
             $sformatf("vec%0d", i));

    // Backpressure: four back-to-back adds, out_ready low for cycles 3..6.
    @(posedge clk); #1;
    outs0 = main_outs; idx = 1; acc = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (c > 1) begin
        @(posedge clk); #1;
      end
      if (acc) idx++;
      in_valid = (idx <= 4); in_a = 64'(idx); in_b = 64'(idx); in_sub = 1'b0;
      out_ready = !(c >= 3 && c <= 6);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (c >= 3 && c <= 6) begin
        check($sformatf("stall%0d_in_ready", c), 132'(in_ready), 132'(0));
        check($sformatf("stall%0d_out_valid", c), 132'(out_valid), 132'(1));
        check($sformatf("stall%0d_out_sum", c), 132'(out_sum), 132'(2));
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    check("stall_result_count", 132'(main_outs - outs0), 132'(4));
    check("stall_queue_empty", 132'(main_q.size()), 132'(0));

    // Reset mid-operation.
    @(posedge clk); #1;
    in_valid = 1'b1; in_a = 64'd10; in_b = 64'd1; in_sub = 1'b0;
    @(posedge clk); #1;
    in_a = 64'd20; in_b = 64'd2;
    @(posedge clk); #3;
    in_valid = 1'b0;
    rst_n = 1'b0;
    main_q.delete();
    #1;
    check("midreset_out_valid", 132'(out_valid), 132'(0));
    check("midreset_out_sum", 132'(out_sum), 132'(0));
    check("midreset_out_flags", 132'(out_flags), 132'(0));
    check("midreset_in_ready", 132'(in_ready), 132'(1));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("postreset_no_stale", 132'(out_valid), 132'(0));
    end
    run_op(64'd3, 64'd4, 1'b0, 64'd7, 4'b0000, "postreset_op");

    // Parameter sweep with random out_ready.
    cyc = 0; min_acc = 0;
    while (min_acc < 1000 && cyc < 10000) begin
      @(posedge clk); #1;
      sw_in_valid = ($urandom_range(0, 4) != 0);
      sw_a = {$urandom, $urandom, $urandom, $urandom};
      sw_b = {$urandom, $urandom, $urandom, $urandom};
      case ($urandom_range(0, 7))
        0: sw_b = sw_a;
        1: sw_b = '1;
        2: sw_a = {1'b0, {127{1'b1}}};
        default: ;
      endcase
      sw_sub = 1'($urandom_range(0, 1));
      sw_out_ready = ($urandom_range(0, 3) != 0);
      cyc++;
      min_acc = sw_acc[0];
      for (int i = 1; i < 4; i++) if (sw_acc[i] < min_acc) min_acc = sw_acc[i];
    end
    check("sweep_finished_in_budget", 132'(cyc < 10000), 132'(1));

    @(posedge clk); #1;
    sw_in_valid = 1'b0; sw_out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      check($sformatf("sweep%0d_drained", i), 132'(sw_q[i].size()), 132'(0));

    // Latency per configuration with out_ready held high.
    for (int i = 0; i < 4; i++) lat[i] = 0;
    sw_in_valid = 1'b1; sw_a = 128'd9; sw_b = 128'd5; sw_sub = 1'b1;
    @(posedge clk); #1;
    sw_in_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      for (int i = 0; i < 4; i++) if (sw_ov[i] && lat[i] == 0) lat[i] = c;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("sweep%0d_latency", i), 132'(lat[i]), 132'(sw_stages(i)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures",
             n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
Parametrised, pipelined integer adder/subtractor for the LEGv8 datapath. It generalises the 64-bit combinational adder in width and pipeline depth, adds a subtract mode and NZCV flag generation for ADDS/SUBS, and adds valid/ready handshaking so it can sit between the execute-stage operand mux and writeback under backpressure. The carry chain is split into STAGES equal segments, with one register stage per segment.

Parameters:
WIDTH, 64, operand/result width in bits; legal values are 8..128.
STAGES, 2, number of pipeline register stages and carry-chain segments; legal values are 1..8. WIDTH % STAGES must be 0, otherwise elaboration fails with a $error.

Ports:
clk  input  1  single clock; rising edge.
rst_n  input  1  asynchronous, active-low reset.
in_valid  input  1  operands presented.
in_ready  output  1  block accepts operands this cycle.
in_a  input  WIDTH  operand A.
in_b  input  WIDTH  operand B.
in_sub  input  1  0 computes A+B; 1 computes A-B.
out_valid  output  1  result available.
out_ready  input  1  consumer accepts result.
out_sum  output  WIDTH  result, modulo 2^WIDTH.
out_flags  output  4  {N,Z,C,V}.

Behaviour:
- Segment width is SEG = WIDTH/STAGES. Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] using the registered carry from stage k-1. Stage 0 uses carry-in = in_sub.
- Effective B: beff = in_sub ? ~in_b : in_b. Subtraction is computed as A + ~B + 1.
- Each stage registers the following:
  - the partial sums already computed;
  - the unprocessed upper operand slices of A and beff;
  - the segment carry;
  - the MSBs of A and beff;
  - a valid bit.
- Latency is exactly STAGES cycles from an accepted input to out_valid, provided out_ready stays high.
- Throughput is one operation per cycle when there is no backpressure.
- Global advance enable is adv = out_ready | ~out_valid. in_ready = adv, combinationally.
  - An input is accepted when in_valid & in_ready.
  - When adv=0, every stage register holds, including valid bits and data.
  - No bubble collapsing: a bubble inside the pipe is held during a stall.
- Register-stage valid bits update only on adv. Stage 0 valid loads in_valid & in_ready.
- out_sum and out_flags are driven from the final registers.
  - They must remain stable while out_valid=1 and out_ready=0.
- Flags are computed combinationally from the last-stage registers:
  - N = sum[WIDTH-1].
  - Z = (sum == 0).
  - C = carry out of bit WIDTH-1. For subtract, C=1 means no borrow (ARM convention).
  - V = (a_msb == beff_msb) & (sum[WIDTH-1] != a_msb).
- Wrap-around: the carry out is not retained beyond C. out_sum wraps modulo 2^WIDTH.
- Reset (rst_n=0, asynchronous, any time including mid-stall):
  - all valid bits clear immediately, so out_valid=0;
  - out_sum=0 and out_flags=4'b0000;
  - all in-flight operations are discarded.
  - in_ready reads 1 during and after reset, because out_valid=0.
- After reset release, the first accepted input produces out_valid exactly STAGES rising edges later.
- STAGES=1 degenerates to a single registered adder: latency 1, with flags still registered-path.
- in_a, in_b and in_sub are ignored when in_valid=0. Garbage data on bubbles is allowed internally but must never appear with out_valid=1.

Test Plan:
- Basic add, WIDTH=64, STAGES=2, out_ready=1. Drive in_a=0x0000_0000_FFFF_FFFF, in_b=1, sub=0. Expected: 2 cycles later out_sum=0x0000_0001_0000_0000, flags=0000. This exercises the inter-segment carry.
- Subtract with borrow and zero. First, A=5, B=7, sub=1 -> out_sum=0xFFFF_FFFF_FFFF_FFFE, flags N=1,Z=0,C=0,V=0. Second, A=B=0x1234 -> sum=0, flags 0110.
- Overflow and wrap. First, A=0x7FFF_FFFF_FFFF_FFFF, B=1 add -> sum=0x8000_0000_0000_0000, flags 1001. Second, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> sum=0, flags 0110.
- Backpressure: stream 4 back-to-back adds (i+i, i=1..4) and hold out_ready=0 for cycles 3..6. Expected:
  - in_ready=0 while stalled;
  - out_sum=2 held stable;
  - after release, results 2,4,6,8 appear in order, with none lost or duplicated.
- Reset mid-operation: accept 2 ops, then assert rst_n=0 between clock edges. Expected:
  - out_valid=0 and out_sum=0 asynchronously;
  - after release, no stale results appear;
  - a new op A=3, B=4 yields 7 after STAGES cycles.
- Parameter sweep (WIDTH,STAGES) = (8,1), (32,4), (64,8), (128,2): 1000 random add/sub ops with random out_ready. Outputs are compared against a reference model of {A±B mod 2^WIDTH, NZCV}, and each configuration's latency equals STAGES under out_ready=1.
